iob_rr_merge: RTL



---
 rtl/iob_rr_merge_pkg.sv | 47 ++++
 rtl/iob_rr_prio_enc.sv | 63 ++++++
 rtl/iob_rr_merge.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/iob_rr_merge_pkg.sv
// -----------------------------------------------------------------------------
// iob_rr_merge_pkg
// Shared interconnect definitions for the IOb round-robin merger:
//   - width helpers for the request/response bundles (REQ_W, RESP_W),
//   - the arbiter index width helper,
//   - the IDLE/BUSY state encoding,
//   - field-extraction macros for request {valid, addr, wdata, wstrb}
//     and response {rdata, ready} bundles.
// No ports (package).
// -----------------------------------------------------------------------------

`ifndef IOB_RR_MERGE_FIELDS
`define IOB_RR_MERGE_FIELDS
// Request bundle layout, MSB first: {valid, addr[ADDR_W], wdata[DATA_W], wstrb[DATA_W/8]}
`define IOB_VALID(req, aw, dw) req[(aw) + (dw) + ((dw) / 8)]
`define IOB_ADDR(req, aw, dw)  req[((dw) + ((dw) / 8)) +: (aw)]
`define IOB_WDATA(req, aw, dw) req[((dw) / 8) +: (dw)]
`define IOB_WSTRB(req, aw, dw) req[0 +: ((dw) / 8)]
// Response bundle layout, MSB first: {rdata[DATA_W], ready}
`define IOB_RDATA(resp, dw)    resp[1 +: (dw)]
`define IOB_READY(resp)        resp[0]
`endif

package iob_rr_merge_pkg;

    // Two-state transaction FSM: IDLE arbitrates, BUSY holds the grant.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Width of one master request slot.
    function automatic int iob_req_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w + (data_w / 8);
    endfunction

    // Width of one master response slot.
    function automatic int iob_resp_w(input int data_w);
        return data_w + 1;
    endfunction

    // Bits needed to hold a master index (at least one bit).
    function automatic int iob_idx_w(input int n_masters);
        return (n_masters > 1) ? $clog2(n_masters) : 1;
    endfunction

endpackage

// File: rtl/iob_rr_prio_enc.sv
// -----------------------------------------------------------------------------
// iob_rr_prio_enc
// Combinational rotate-and-find-first. Searches the valid vector starting at
// index ptr and wrapping modulo N_MASTERS; reports the first set index.
// Ports:
//   valid      in  N_MASTERS  request valid bits, one per master
//   ptr        in  IDX_W      index searched first
//   winner     out N_MASTERS  one-hot winner (all zero when nothing valid)
//   winner_idx out IDX_W      binary index of the winner (0 when nothing valid)
//   any        out 1          at least one valid bit set
// -----------------------------------------------------------------------------
module iob_rr_prio_enc #(
    parameter int N_MASTERS = 2,
    parameter int IDX_W     = 1
) (
    input  logic [N_MASTERS-1:0] valid,
    input  logic [IDX_W-1:0]     ptr,
    output logic [N_MASTERS-1:0] winner,
    output logic [IDX_W-1:0]     winner_idx,
    output logic                 any
);

    // One extra bit so ptr + offset never overflows before the modulo fold.
    localparam logic [IDX_W:0] N_L = (IDX_W + 1)'(N_MASTERS);

    logic [IDX_W:0] cand_s;
    logic           found_s;

    // Walk ptr, ptr+1, ... and latch the first requesting index. The fold is a
    // compare-and-subtract so non-power-of-two master counts wrap correctly.
    always_comb begin
        cand_s     = '0;
        found_s    = 1'b0;
        winner_idx = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            cand_s = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (cand_s >= N_L) begin
                cand_s = cand_s - N_L;
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && valid[cand_s[IDX_W-1:0]]) begin
                found_s    = 1'b1;
                winner_idx = cand_s[IDX_W-1:0];
            end else begin
                found_s    = found_s;
            end
        end
    end

    // Expand the binary winner to one-hot; empty when nobody requests.
    always_comb begin
        winner = '0;
        if (found_s) begin
            winner[winner_idx] = 1'b1;
        end else begin
            winner = '0;
        end
    end

    assign any = |valid;

endmodule

// File: rtl/iob_rr_merge.sv
// -----------------------------------------------------------------------------
// iob_rr_merge
// Round-robin N-to-1 merger for the IOb native bus. One transaction is
// outstanding at a time; the grant is held until the slave pulses ready, then
// the priority pointer moves just past the master that was served.
// Ports:
//   clk     in  1                   system clock
//   rst     in  1                   asynchronous active-high reset
//   m_req   in  N_MASTERS*REQ_W     master requests, slot i at [i*REQ_W +: REQ_W]
//   m_resp  out N_MASTERS*RESP_W    master responses, slot i at [i*RESP_W +: RESP_W]
//   s_req   out REQ_W               request to the shared slave
//   s_resp  in  RESP_W              response from the shared slave
//   grant   out N_MASTERS           one-hot current owner, zero when idle
// -----------------------------------------------------------------------------
module iob_rr_merge
    import iob_rr_merge_pkg::*;
#(
    parameter  int N_MASTERS = 2,
    parameter  int ADDR_W    = 32,
    parameter  int DATA_W    = 32,
    localparam int REQ_W     = iob_req_w(ADDR_W, DATA_W),
    localparam int RESP_W    = iob_resp_w(DATA_W)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS*REQ_W-1:0]    m_req,
    output logic [N_MASTERS*RESP_W-1:0]   m_resp,
    output logic [REQ_W-1:0]              s_req,
    input  logic [RESP_W-1:0]             s_resp,
    output logic [N_MASTERS-1:0]          grant
);

    localparam int             IDX_W    = iob_idx_w(N_MASTERS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MASTERS - 1);

    state_e               state_r, state_n;
    logic [N_MASTERS-1:0] grant_r, grant_n;
    logic [IDX_W-1:0]     gidx_r,  gidx_n;
    logic [IDX_W-1:0]     ptr_r,   ptr_n;

    logic [REQ_W-1:0]     req_slot_s [N_MASTERS];
    logic [N_MASTERS-1:0] valid_s;
    logic [N_MASTERS-1:0] win_onehot_s;
    logic [IDX_W-1:0]     win_idx_s;
    logic                 win_any_s;
    logic                 ready_s;

    // Unpack the flat request bus into per-master slots and their valid bits.
    for (genvar i = 0; i < N_MASTERS; i++) begin : g_slot
        assign req_slot_s[i] = m_req[i*REQ_W +: REQ_W];
        assign valid_s[i]    = `IOB_VALID(req_slot_s[i], ADDR_W, DATA_W);
    end

    assign ready_s = `IOB_READY(s_resp);

    // Arbitration only looks at registered ptr, so s_resp never reaches the
    // grant decision combinationally.
    iob_rr_prio_enc #(
        .N_MASTERS (N_MASTERS),
        .IDX_W     (IDX_W)
    ) u_prio_enc (
        .valid      (valid_s),
        .ptr        (ptr_r),
        .winner     (win_onehot_s),
        .winner_idx (win_idx_s),
        .any        (win_any_s)
    );

    // State, grant and rotation pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            grant_r <= '0;
            gidx_r  <= '0;
            ptr_r   <= '0;
        end else begin
            state_r <= state_n;
            grant_r <= grant_n;
            gidx_r  <= gidx_n;
            ptr_r   <= ptr_n;
        end
    end

    // Next-state logic: grant on any request in IDLE, release on slave ready.
    always_comb begin
        state_n = state_r;
        grant_n = grant_r;
        gidx_n  = gidx_r;
        ptr_n   = ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (win_any_s) begin
                    state_n = ST_BUSY;
                    grant_n = win_onehot_s;
                    gidx_n  = win_idx_s;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // A dropped valid from the owner does not end the transaction;
                // only the slave's ready does.
                if (ready_s) begin
                    state_n = ST_IDLE;
                    grant_n = '0;
                    if (gidx_r == LAST_IDX) begin
                        ptr_n = '0;
                    end else begin
                        ptr_n = gidx_r + IDX_W'(1);
                    end
                end else begin
                    state_n = ST_BUSY;
                end
            end
            default: begin
                state_n = ST_IDLE;
                grant_n = '0;
                gidx_n  = '0;
            end
        endcase
    end

    // Forward the owner's request to the slave; slave sees valid=0 when idle.
    always_comb begin
        s_req = '0;
        if (state_r == ST_BUSY) begin
            s_req = req_slot_s[gidx_r];
        end else begin
            s_req = '0;
        end
    end

    // Route the slave response to the owner only; everyone else sees zeros.
    always_comb begin
        m_resp = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if ((state_r == ST_BUSY) && grant_r[i]) begin
                m_resp[i*RESP_W +: RESP_W] = s_resp;
            end else begin
                m_resp[i*RESP_W +: RESP_W] = '0;
            end
        end
    end

    assign grant = grant_r;

endmodule
